// File: rtl/avst_word_assembler.sv
// avst_word_assembler
// ---------------------------------------------------------------------------
// Downstream stage of the byte-serial Avalon-ST adder. Collects one packet of
// 8-bit beats (valid/ready, end marks the last byte) into a BYTES-wide word.
// Each word is tagged with its byte count and a length-error flag. It is then
// queued in a small output FIFO, so the byte side is decoupled from the
// word-side consumer.
//
// Optional feature (compile-time macro WORD_ASM_TIMEOUT_EN):
//   When defined, a partial packet that sees TIMEOUT_CYCLES idle cycles
//   (in-packet, valid_in low) is flushed with err=1 and len = bytes so far.
//   When undefined, a partial packet waits indefinitely.
//
// Parameters:
//   BYTES          bytes per word (word_out is 8*BYTES bits)
//   MSB_FIRST      1: byte 0 lands in the most significant lane, 0: least
//   FIFO_DEPTH     output FIFO entries, power of two, >= 2
//   TIMEOUT_CYCLES idle limit, only used with WORD_ASM_TIMEOUT_EN
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   data_in/end_in        packet byte and last-byte marker
//   valid_in/ready_in     byte-side handshake (ready_in = FIFO not full)
//   word_out/len_out/err_out  FIFO head entry, all zero when empty
//   valid_out/ready_out   word-side handshake (valid_out = FIFO not empty)
// ---------------------------------------------------------------------------
module avst_word_assembler #(
    parameter int BYTES          = 4,
    parameter bit MSB_FIRST      = 1'b1,
    parameter int FIFO_DEPTH     = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           data_in,
    input  logic                 end_in,
    input  logic                 valid_in,
    output logic                 ready_in,
    output logic [8*BYTES-1:0]   word_out,
    output logic [7:0]           len_out,
    output logic                 err_out,
    output logic                 valid_out,
    input  logic                 ready_out
);

    localparam int W  = 8 * BYTES;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    // Packet accumulator and byte counter; in-packet is simply cnt_q != 0.
    logic [W-1:0]    acc_q, acc_d, acc_merged;
    logic [7:0]      cnt_q, cnt_d, cnt_inc;

    // Output FIFO
    logic [W-1:0]    mem_word [FIFO_DEPTH];
    logic [7:0]      mem_len  [FIFO_DEPTH];
    logic            mem_err  [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            fifo_full, fifo_empty;
    logic            beat, end_beat, flush, push, pop;
    logic [W-1:0]    push_word;
    logic [7:0]      push_len;
    logic            push_err;

    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);

    // ready_in depends on registered FIFO occupancy only, never on valid_in.
    assign ready_in   = !fifo_full;
    assign valid_out  = !fifo_empty;

    assign beat     = valid_in && !fifo_full;
    assign end_beat = beat && end_in;
    assign pop      = !fifo_empty && ready_out;

    assign cnt_inc = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;

    // Accumulator with the current byte dropped into its lane. A lane whose
    // byte index never matches the counter keeps its old value; bytes past
    // BYTES match no lane and are therefore dropped.
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
        localparam logic [7:0] LANE_IDX = MSB_FIRST ? 8'(BYTES - 1 - gi) : 8'(gi);
        assign acc_merged[gi*8 +: 8] = (cnt_q == LANE_IDX) ? data_in : acc_q[gi*8 +: 8];
    end

`ifdef WORD_ASM_TIMEOUT_EN
    localparam int             IW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0]  IDLE_LIMIT = IW'(TIMEOUT_CYCLES);

    logic [IW-1:0] idle_q, idle_d;
    logic          expired;

    // Once expired the counter holds; the flush then waits for FIFO space.
    // A byte arriving in the meantime takes priority and restarts the count.
    assign expired = (cnt_q != 8'd0) && (idle_q == IDLE_LIMIT);
    assign flush   = expired && !beat && !fifo_full;

    always_comb begin
        idle_d = idle_q;
        if (beat || flush) begin
            idle_d = '0;
        end else if ((cnt_q != 8'd0) && !valid_in && !expired) begin
            idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign flush = 1'b0;
`endif

    assign push      = end_beat || flush;
    assign push_word = flush ? acc_q : acc_merged;
    assign push_len  = flush ? cnt_q : cnt_inc;
    assign push_err  = flush ? 1'b1 : (cnt_inc != 8'(BYTES));

    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            acc_d = '0;
            cnt_d = 8'd0;
        end else if (beat) begin
            acc_d = acc_merged;
            cnt_d = cnt_inc;
        end

        // Depth is a power of two, so the pointers wrap naturally.
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            cnt_q    <= 8'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_word[wr_ptr_q] <= push_word;
            mem_len[wr_ptr_q]  <= push_len;
            mem_err[wr_ptr_q]  <= push_err;
        end
    end

    assign word_out = fifo_empty ? '0    : mem_word[rd_ptr_q];
    assign len_out  = fifo_empty ? 8'd0  : mem_len[rd_ptr_q];
    assign err_out  = fifo_empty ? 1'b0  : mem_err[rd_ptr_q];

endmodule

// File: tb/tb_avst_word_assembler.sv
// Testbench for avst_word_assembler: two instances (MSB_FIRST=1 and 0) share
// the byte-side stimulus. A packet-level model (byte list -> word) predicts
// the FIFO contents, and every cycle the outputs of both instances are
// compared with it. Popped words are logged and checked against literals.
module tb_avst_word_assembler;

    localparam int BYTES = 4;
    localparam int DEPTH = 2;
    localparam int TOUT  = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  data_in;
    logic        end_in;
    logic        valid_in;
    logic        ready_out;

    logic        ready_in,  ready_in_l;
    logic [31:0] word_out,  word_out_l;
    logic [7:0]  len_out,   len_out_l;
    logic        err_out,   err_out_l;
    logic        valid_out, valid_out_l;

    always #5 clk = ~clk;

    avst_word_assembler #(
        .BYTES(BYTES), .MSB_FIRST(1'b1), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .end_in(end_in),
        .valid_in(valid_in), .ready_in(ready_in), .word_out(word_out),
        .len_out(len_out), .err_out(err_out), .valid_out(valid_out),
        .ready_out(ready_out)
    );

    avst_word_assembler #(
        .BYTES(BYTES), .MSB_FIRST(1'b0), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TOUT)
    ) dut_l (
        .clk(clk), .reset(reset), .data_in(data_in), .end_in(end_in),
        .valid_in(valid_in), .ready_in(ready_in_l), .word_out(word_out_l),
        .len_out(len_out_l), .err_out(err_out_l), .valid_out(valid_out_l),
        .ready_out(ready_out)
    );

    typedef struct packed {
        logic [31:0] wm;   // expected word, MSB-first lane order
        logic [31:0] wl;   // expected word, LSB-first lane order
        logic [7:0]  len;
        logic        err;
    } ent_t;

    ent_t        q[$];          // model of FIFO contents
    ent_t        got[$];        // words actually popped from the DUTs
    logic [7:0]  pkt_b [BYTES]; // first BYTES bytes of the current packet
    int          cnt;           // bytes received so far in current packet
    int          idle;
    bit          model_on = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] got_v, input logic [63:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got_v, exp_v, $time);
        end
    endtask

    function automatic ent_t mk(input int n, input logic e);
        ent_t r;
        r = '0;
        for (int k = 0; k < BYTES && k < n; k++) begin
            r.wm[(BYTES-1-k)*8 +: 8] = pkt_b[k];
            r.wl[k*8 +: 8]           = pkt_b[k];
        end
        r.len = (n > 255) ? 8'hFF : 8'(n);
        r.err = e;
        return r;
    endfunction

    // Packet-level model, advanced on every clock edge.
    initial begin
        cnt  = 0;
        idle = 0;
        forever begin
            @(posedge clk);
            if (reset) begin
                q.delete();
                cnt      = 0;
                idle     = 0;
                model_on = 1'b1;
            end else if (model_on) begin
                int  sz;
                bit  acc, pop, fl;
                int  lsat;
                sz  = q.size();
                acc = valid_in && (sz < DEPTH);
                pop = (sz > 0) && ready_out;
                fl  = 1'b0;
`ifdef WORD_ASM_TIMEOUT_EN
                fl  = !acc && (cnt > 0) && (idle == TOUT) && (sz < DEPTH);
`endif
                if (valid_out && ready_out)
                    got.push_back('{word_out, word_out_l, len_out, err_out});
                if (pop) void'(q.pop_front());
                if (acc) begin
                    if (cnt < BYTES) pkt_b[cnt] = data_in;
                    cnt++;
                    if (end_in) begin
                        lsat = (cnt > 255) ? 255 : cnt;
                        q.push_back(mk(cnt, lsat != BYTES));
                        cnt = 0;
                    end
                end else if (fl) begin
                    q.push_back(mk(cnt, 1'b1));
                    cnt = 0;
                end
`ifdef WORD_ASM_TIMEOUT_EN
                if (acc || fl) idle = 0;
                else if (cnt > 0 && !valid_in && idle < TOUT) idle++;
`endif
            end
        end
    end

    // Per-cycle compare of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (model_on && !reset) begin
                ent_t h;
                bit   ev, er;
                ev = q.size() > 0;
                er = q.size() < DEPTH;
                h  = ev ? q[0] : '0;
                chk("ready_in",    ready_in,    er);
                chk("valid_out",   valid_out,   ev);
                chk("word_out",    word_out,    h.wm);
                chk("len_out",     len_out,     h.len);
                chk("err_out",     err_out,     h.err);
                chk("ready_in_l",  ready_in_l,  er);
                chk("valid_out_l", valid_out_l, ev);
                chk("word_out_l",  word_out_l,  h.wl);
                chk("len_out_l",   len_out_l,   h.len);
                chk("err_out_l",   err_out_l,   h.err);
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic beat(input logic [7:0] d, input logic e);
        @(negedge clk);
        valid_in = 1'b1;
        data_in  = d;
        end_in   = e;
        for (int t = 0; ; t++) begin
            if (ready_in === 1'b1) begin
                @(posedge clk);
                return;
            end
            if (t == 200) begin
                checks++;
                errors++;
                $display("FAIL beat_stall got ready_in=0 expected ready_in=1 within 200 cycles");
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle_cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_in = 1'b0;
            end_in   = 1'b0;
        end
    endtask

    task automatic send4(input logic [31:0] w);
        for (int k = 0; k < 4; k++) beat(w[31-8*k -: 8], k == 3);
    endtask

    initial begin
        reset     = 1'b1;
        data_in   = 8'h00;
        end_in    = 1'b0;
        valid_in  = 1'b0;
        ready_out = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst_ready_in",  ready_in,  1'b1);
        chk("rst_valid_out", valid_out, 1'b0);
        chk("rst_word_out",  word_out,  32'h0);
        chk("rst_len_out",   len_out,   8'h0);
        chk("rst_err_out",   err_out,   1'b0);

        // Good 4-byte packet, both lane orders
        got.delete();
        send4(32'h11223344);
        idle_cyc(4);
        chk("t1_count", got.size(), 1);
        if (got.size() >= 1) begin
            chk("t1_word_msb", got[0].wm, 32'h11223344);
            chk("t1_word_lsb", got[0].wl, 32'h44332211);
            chk("t1_len",      got[0].len, 8'd4);
            chk("t1_err",      got[0].err, 1'b0);
        end

        // Short packet
        got.delete();
        beat(8'hAA, 1'b0);
        beat(8'hBB, 1'b1);
        idle_cyc(3);
        chk("t2_count", got.size(), 1);
        if (got.size() >= 1) begin
            chk("t2_word_msb", got[0].wm, 32'hAABB0000);
            chk("t2_word_lsb", got[0].wl, 32'h0000BBAA);
            chk("t2_len",      got[0].len, 8'd2);
            chk("t2_err",      got[0].err, 1'b1);
        end

        // Long packet, then a normal one
        got.delete();
        for (int k = 1; k <= 6; k++) beat(8'(k), k == 6);
        send4(32'hCAFE0102);
        idle_cyc(3);
        chk("t3_count", got.size(), 2);
        if (got.size() >= 2) begin
            chk("t3_word_msb", got[0].wm, 32'h01020304);
            chk("t3_len",      got[0].len, 8'd6);
            chk("t3_err",      got[0].err, 1'b1);
            chk("t3_next",     got[1].wm, 32'hCAFE0102);
            chk("t3_next_err", got[1].err, 1'b0);
        end

        // Backpressure: two words buffered, third packet stalls
        got.delete();
        ready_out = 1'b0;
        fork
            begin
                send4(32'hA0A1A2A3);
                send4(32'hB0B1B2B3);
                send4(32'hC0C1C2C3);
            end
            begin
                repeat (40) @(negedge clk);
                chk("t4_stall_ready_in", ready_in, 1'b0);
                chk("t4_stall_valid",    valid_out, 1'b1);
                chk("t4_stall_head",     word_out, 32'hA0A1A2A3);
                chk("t4_stall_nopop",    got.size(), 0);
                ready_out = 1'b1;
            end
        join
        idle_cyc(6);
        chk("t4_count", got.size(), 3);
        if (got.size() >= 3) begin
            chk("t4_w0", got[0].wm, 32'hA0A1A2A3);
            chk("t4_w1", got[1].wm, 32'hB0B1B2B3);
            chk("t4_w2", got[2].wm, 32'hC0C1C2C3);
        end

        // Mid-packet reset discards the partial packet
        got.delete();
        beat(8'h55, 1'b0);
        beat(8'h66, 1'b0);
        @(negedge clk);
        valid_in = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        send4(32'h11223344);
        idle_cyc(4);
        chk("t5_count", got.size(), 1);
        if (got.size() >= 1) begin
            chk("t5_word", got[0].wm, 32'h11223344);
            chk("t5_err",  got[0].err, 1'b0);
        end

        // Length counter saturates at 255
        got.delete();
        for (int k = 0; k < 300; k++) beat(8'(k), k == 299);
        idle_cyc(3);
        chk("t6_count", got.size(), 1);
        if (got.size() >= 1) begin
            chk("t6_word", got[0].wm, 32'h00010203);
            chk("t6_len",  got[0].len, 8'hFF);
            chk("t6_err",  got[0].err, 1'b1);
        end

        // Randomized traffic, checked cycle by cycle against the model
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            reset     = (i == 400);
            valid_in  = ($urandom_range(0, 9) < 7);
            data_in   = 8'($urandom);
            end_in    = ($urandom_range(0, 3) == 0);
            ready_out = ($urandom_range(0, 9) < 6);
        end
        @(negedge clk);
        reset     = 1'b0;
        valid_in  = 1'b0;
        end_in    = 1'b0;
        ready_out = 1'b1;
        idle_cyc(8);

`ifdef WORD_ASM_TIMEOUT_EN
        // Idle timeout flushes a one-byte partial packet
        got.delete();
        beat(8'h5A, 1'b0);
        idle_cyc(TOUT + 10);
        chk("t7_count", got.size(), 1);
        if (got.size() >= 1) begin
            chk("t7_word", got[0].wm, 32'h5A000000);
            chk("t7_len",  got[0].len, 8'd1);
            chk("t7_err",  got[0].err, 1'b1);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/avst_word_assembler.md
Name: avst_word_assembler

Overview:
- Downstream stage of the byte-serial Avalon-ST adder.
- Collects an 8-bit packet stream, framed by valid/ready/end, into one BYTES-wide word per packet.
- Tags each word with its byte count and a length-error flag, and buffers results in a small output FIFO toward the word-side consumer (register bank / scoreboard port).
- Decouples the byte-side handshake from the word-side consumer.

Parameters:
- BYTES, 4: bytes per assembled word; word_out is 8*BYTES bits.
- MSB_FIRST, 1: 1 = first byte of a packet lands in the most significant lane; 0 = least significant lane.
- FIFO_DEPTH, 2: output FIFO entries, power of two, ≥2.
- TIMEOUT_CYCLES, 256: idle-cycle limit for the optional timeout feature; ignored when the feature is compiled out.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- data_in  input  8  packet byte.
- end_in  input  1  marks the last byte of a packet.
- valid_in  input  1  byte-side valid.
- ready_in  output  1  byte-side ready.
- word_out  output  8*BYTES  assembled word at FIFO head.
- len_out  output  8  bytes received in that packet, saturating at 255.
- err_out  output  1  length error (or timeout) for that packet.
- valid_out  output  1  word-side valid.
- ready_out  input  1  word-side ready.

Behaviour:
- Interface: clock clk; reset reset, synchronous, active-high.
- Reset values:
  - ready_in=1, valid_out=0.
  - word_out=0, len_out=0, err_out=0.
  - Accumulator, byte counter and FIFO pointers cleared.
  - A partial packet in progress at reset is discarded; a mid-packet reset never yields an output word.
- Byte beat: occurs on a clock edge where valid_in && ready_in.
- Lane mapping: byte index k (0-based in packet), k<BYTES, is written to lane k if MSB_FIRST=0, or lane BYTES-1-k if MSB_FIRST=1.
  - Bytes with k≥BYTES are counted but dropped.
  - Lanes not written in the packet read 0.
- Byte counter: increments per beat, saturates at 255.
- End beat: pushes {word incl. this byte, len=count+1 (saturating), err=(len!=BYTES)} into the FIFO in the same cycle, then clears the accumulator and counter.
  - A one-byte packet is legal (len=1, err=1 when BYTES>1).
- ready_in is combinational: it equals !fifo_full and is driven only from registered FIFO state.
  - While full, all beats stall, including non-end beats.
- valid_out = !fifo_empty.
  - word_out/len_out/err_out show the head entry, and read 0 when empty.
  - Head is stable while valid_out && !ready_out.
  - Pop occurs on valid_out && ready_out.
- Latency: end beat accepted at edge N gives valid_out=1 after edge N (1 cycle), provided the FIFO was empty.
- Simultaneous push and pop: count unchanged, data ordering preserved.
  - Push is impossible when full, since ready_in=0.
  - A pop while full re-raises ready_in in the next cycle.
- No state machine beyond idle/in-packet: in-packet = counter≠0.

Optional Feature:
- Macro: WORD_ASM_TIMEOUT_EN.
- Defined:
  - An idle counter runs while in-packet and valid_in=0.
  - On reaching TIMEOUT_CYCLES, the partial word is pushed with err=1 and len=bytes so far, then the assembler returns to idle.
  - If the FIFO is full at expiry, the flush waits until space is available.
  - Any byte beat resets the idle counter.
- Undefined: no idle counter; a partial packet waits indefinitely.

Test Plan:
- After reset, send 0x11,0x22,0x33,0x44 (end on 0x44) with MSB_FIRST=1, ready_out=1 -> word_out=0x11223344, len=4, err=0, valid_out for exactly 1 cycle.
- Same bytes with MSB_FIRST=0 -> word_out=0x44332211, len=4, err=0.
- Short packet 0xAA,0xBB (end) with MSB_FIRST=1 -> word_out=0xAABB0000, len=2, err=1.
- Long packet of 6 bytes 0x01..0x06 -> word_out=0x01020304, len=6, err=1; next packet unaffected.
- Hold ready_out=0 and send 3 good packets -> 2 words buffered, ready_in=0 stalls the third packet's bytes. Release ready_out -> words pop in order, third packet completes, no loss.
- Assert reset after 2 bytes of a packet, then send a full 4-byte packet -> only that packet's word appears. With WORD_ASM_TIMEOUT_EN: send 1 byte, then idle for 256 cycles -> flushed word, len=1, err=1.
